uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_tx` transmitter between `NUM_REQ` byte producers. It grants one requester at a time and registers that requester's byte. It then pulses `tx_start` into the transmitter and tracks the transmitter's `busy` through the whole frame before granting again. It sits between the command/status sources and the single UART TX line.

---
 rtl/uart_arb_pkg.sv | 14 +
 rtl/uart_rr_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and limits for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first set req bit after 'last', wrapping to 0.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester after 'last' overwrites.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = IDX_W'((int'(last) + off) % NUM_REQ);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Optional UART_ARB_LOCK_EN adds req_lock for back-to-back grants to one owner.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int BUSY_TO = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   req_lock,
`endif
    output logic [NUM_REQ-1:0]   ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 err
);

    localparam int CNT_W = $clog2(BUSY_TO + 1);

    arb_state_t       state;
    logic [IDX_W-1:0] last;
    logic [CNT_W-1:0] cnt;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    logic [7:0]       req_bytes [NUM_REQ];
`ifdef UART_ARB_LOCK_EN
    logic             lock_active;
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
        assign req_bytes[i] = req_data[8*i +: 8];
    end

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A held lock overrides rotation only while the owner still has a byte pending.
    always_comb begin
        sel_valid = pick_valid;
        sel_idx   = pick_idx;
`ifdef UART_ARB_LOCK_EN
        if (lock_active && req[grant_id]) begin
            sel_valid = 1'b1;
            sel_idx   = grant_id;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (NUM_REQ >= NUM_REQ_MIN && NUM_REQ <= NUM_REQ_MAX);
            state       <= IDLE;
            last        <= IDX_W'(NUM_REQ - 1);
            cnt         <= '0;
            ack         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            err         <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_active <= 1'b0;
`endif
        end else begin
            ack      <= '0;
            tx_start <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
`ifdef UART_ARB_LOCK_EN
                    if (lock_active && !req[grant_id]) begin
                        lock_active <= 1'b0;
                    end
`endif
                    if (sel_valid && !tx_busy) begin
                        grant_id    <= sel_idx;
                        tx_data     <= req_bytes[sel_idx];
                        grant_valid <= 1'b1;
                        tx_start    <= 1'b1;
                        ack         <= NUM_REQ'(1) << sel_idx;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    last  <= grant_id;
                    cnt   <= CNT_W'(BUSY_TO);
                    state <= WAIT_BUSY;
`ifdef UART_ARB_LOCK_EN
                    lock_active <= req_lock[grant_id];
`endif
                end
                // Counter reaching the end drops the frame; ack was already given.
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt <= CNT_W'(1)) begin
                        err         <= 1'b1;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the lock test is built only with UART_ARB_LOCK_EN.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int BUSY_TO = 4;
    localparam int IDX_W   = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   ack;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy = 1'b0;
    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_id;
    logic                 err;
`ifdef UART_ARB_LOCK_EN
    logic [NUM_REQ-1:0]   req_lock = '0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .BUSY_TO (BUSY_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
`ifdef UART_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .ack         (ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .err         (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic busy);
        req     = r;
        tx_busy = busy;
    endtask

    task automatic resetDut;
        rst = 1'b1;
        applyStimulus('0, 1'b0);
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ack"}, 32'(ack), 0);
        checkOutput({tag, "_start"}, 32'(tx_start), 0);
        checkOutput({tag, "_data"}, 32'(tx_data), 0);
        checkOutput({tag, "_gv"}, 32'(grant_valid), 0);
        checkOutput({tag, "_gid"}, 32'(grant_id), 0);
        checkOutput({tag, "_err"}, 32'(err), 0);
    endtask

    // One full frame with a well-behaved transmitter; drops req after ack, optionally re-requests.
    task automatic runFrame(input int exp_id, input logic [7:0] exp_data, input bit rereq);
        int n;
        n = 0;
        while (tx_start !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        checkOutput("latency", 32'(n), 1);
        checkOutput("grant_id", 32'(grant_id), 32'(exp_id));
        checkOutput("ack", 32'(ack), 32'(1) << exp_id);
        checkOutput("tx_data", 32'(tx_data), 32'(exp_data));
        checkOutput("gv_grant", 32'(grant_valid), 1);
        req[exp_id] = 1'b0;
        tick;
        checkOutput("start_low", 32'(tx_start), 0);
        checkOutput("ack_low", 32'(ack), 0);
        if (rereq) req[exp_id] = 1'b1;
        tx_busy = 1'b1;
        repeat (3) tick;
        checkOutput("gv_busy", 32'(grant_valid), 1);
        tx_busy = 1'b0;
        tick;
        checkOutput("gv_drop", 32'(grant_valid), 0);
    endtask

    initial begin
        int k;
        int sc;

        for (int i = 0; i < NUM_REQ; i++) req_data[8*i +: 8] = 8'hA0 + 8'(i);

        // Reset values while rst is held
        rst = 1'b1;
        tick;
        tick;
        checkResetOutputs("rst");
        rst = 1'b0;

        // Single request from requester 0
        req_data[7:0] = 8'h65;
        applyStimulus(4'b0001, 1'b0);
        runFrame(0, 8'h65, 1'b0);
        tick;
        checkOutput("data_hold", 32'(tx_data), 32'h65);
        req_data[7:0] = 8'hA0;

        // All four requesting, re-requesting after every ack
        resetDut;
        applyStimulus(4'b1111, 1'b0);
        for (int f = 0; f < 8; f++) runFrame(f % 4, 8'hA0 + 8'(f % 4), 1'b1);

        // Transmitter never answers: err after BUSY_TO+1 cycles
        resetDut;
        applyStimulus(4'b0100, 1'b0);
        tick;
        checkOutput("to_start", 32'(tx_start), 1);
        req = 4'b0000;
        k = 0;
        do begin
            tick;
            k++;
        end while (err !== 1'b1 && k < 20);
        checkOutput("to_delay", 32'(k), BUSY_TO + 1);
        checkOutput("to_gv", 32'(grant_valid), 0);
        req = 4'b0100;
        tick;
        checkOutput("to_err_pulse", 32'(err), 0);
        checkOutput("to_regrant", 32'(tx_start), 1);
        checkOutput("to_regrant_id", 32'(grant_id), 2);

        // Reset while the frame is in WAIT_DONE, transmitter still busy
        resetDut;
        applyStimulus(4'b0001, 1'b0);
        tick;
        req = 4'b0000;
        tick;
        tx_busy = 1'b1;
        tick;
        tick;
        checkOutput("mid_gv_before", 32'(grant_valid), 1);
        rst = 1'b1;
        req = 4'b0010;
        tick;
        checkResetOutputs("mid");
        rst = 1'b0;
        sc = 0;
        repeat (4) begin
            tick;
            if (tx_start === 1'b1) sc++;
        end
        checkOutput("mid_no_start", 32'(sc), 0);
        tx_busy = 1'b0;
        tick;
        checkOutput("mid_start", 32'(tx_start), 1);
        checkOutput("mid_gid", 32'(grant_id), 1);

        // Busy at reset release holds off the grant
        rst = 1'b1;
        applyStimulus(4'b0100, 1'b1);
        tick;
        rst = 1'b0;
        sc = 0;
        repeat (3) begin
            tick;
            if (tx_start === 1'b1) sc++;
        end
        checkOutput("busy_no_start", 32'(sc), 0);
        tx_busy = 1'b0;
        tick;
        checkOutput("busy_start", 32'(tx_start), 1);
        checkOutput("busy_gid", 32'(grant_id), 2);
        checkOutput("busy_ack", 32'(ack), 32'b0100);

`ifdef UART_ARB_LOCK_EN
        // Requester 1 locks the line for three frames, then 0 follows
        resetDut;
        req_lock = 4'b0010;
        applyStimulus(4'b0011, 1'b0);
        runFrame(0, 8'hA0, 1'b1);
        runFrame(1, 8'hA1, 1'b1);
        runFrame(1, 8'hA1, 1'b1);
        runFrame(1, 8'hA1, 1'b0);
        runFrame(0, 8'hA0, 1'b0);
        req_lock = 4'b0000;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
